// File: rtl/bstep_rate_decoder_6bit_if.sv
// Valid/ready stream bundle used on both sides of the rate decoder.
// The master drives data and valid. The slave drives ready.
interface bstep_rate_decoder_6bit_if #(
   parameter int unsigned Width = 1
);
   logic [Width-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bstep_rate_decoder_6bit.sv
// Rate decoder for a binary-step activation stream. It counts the '1' samples over a window
// of Window accepted samples and emits the count as a 6-bit word through a valid/ready handshake.
module bstep_rate_decoder_6bit #(
   parameter int unsigned Window = 63
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   bstep_rate_decoder_6bit_if.slave   in_io,
   bstep_rate_decoder_6bit_if.master  out_io
);

   localparam logic StAccum = 1'b0;
   localparam logic StHold  = 1'b1;

   logic       state_q, state_d;
   logic [5:0] samp_q, samp_d;
   logic [5:0] ones_q, ones_d;
   logic [5:0] out_q, out_d;
   logic       out_valid_q, out_valid_d;

   logic       accept;
   logic [5:0] samp_inc;
   logic [5:0] ones_inc;

   // Ready depends only on state, so upstream never sees a combinational path through valid.
   assign in_io.ready  = (state_q == StAccum);
   assign out_io.data  = out_q;
   assign out_io.valid = out_valid_q;

   assign accept   = in_io.valid & in_io.ready & ~clear_i;
   assign samp_inc = samp_q + 6'd1;
   assign ones_inc = ones_q + {5'd0, in_io.data[0]};

   always_comb begin
      state_d     = state_q;
      samp_d      = samp_q;
      ones_d      = ones_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (clear_i) begin
         state_d     = StAccum;
         samp_d      = 6'd0;
         ones_d      = 6'd0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            StAccum: begin
               if (accept) begin
                  if (samp_inc == 6'(Window)) begin
                     out_d       = ones_inc;
                     samp_d      = 6'd0;
                     ones_d      = 6'd0;
                     out_valid_d = 1'b1;
                     state_d     = StHold;
                  end else begin
                     samp_d = samp_inc;
                     ones_d = ones_inc;
                  end
               end
            end
            StHold: begin
               if (out_io.ready) begin
                  out_valid_d = 1'b0;
                  state_d     = StAccum;
               end
            end
            default: state_d = StAccum;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StAccum;
         samp_q      <= 6'd0;
         ones_q      <= 6'd0;
         out_q       <= 6'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         samp_q      <= samp_d;
         ones_q      <= ones_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_bstep_rate_decoder_6bit.sv
// Self-checking bench: three decoders (windows 63, 8 and 1) driven by directed and random stimulus.
module tb_bstep_rate_decoder_6bit;

   logic clk;
   logic rst;
   logic clear_a, clear_b, clear_c;

   int tests_run    = 0;
   int tests_failed = 0;

   bstep_rate_decoder_6bit_if #(.Width(1)) a_in ();
   bstep_rate_decoder_6bit_if #(.Width(6)) a_out ();
   bstep_rate_decoder_6bit_if #(.Width(1)) b_in ();
   bstep_rate_decoder_6bit_if #(.Width(6)) b_out ();
   bstep_rate_decoder_6bit_if #(.Width(1)) c_in ();
   bstep_rate_decoder_6bit_if #(.Width(6)) c_out ();

   bstep_rate_decoder_6bit #(.Window(63)) dut_a (
      .clk_i(clk), .rst_i(rst), .clear_i(clear_a), .in_io(a_in.slave), .out_io(a_out.master)
   );
   bstep_rate_decoder_6bit #(.Window(8)) dut_b (
      .clk_i(clk), .rst_i(rst), .clear_i(clear_b), .in_io(b_in.slave), .out_io(b_out.master)
   );
   bstep_rate_decoder_6bit #(.Window(1)) dut_c (
      .clk_i(clk), .rst_i(rst), .clear_i(clear_c), .in_io(c_in.slave), .out_io(c_out.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams bits into decoder B with Out_ready high and returns the first output word.
   task automatic stream_b(input bit bits[$], output logic [5:0] val, output bit got);
      int k = 0;
      int cyc = 0;
      got = 1'b0;
      val = '0;
      b_out.ready = 1'b1;
      while (cyc < 200 && !got) begin
         if (b_out.valid === 1'b1) begin
            val = b_out.data;
            got = 1'b1;
            b_in.valid = 1'b0;
            tick();
         end else begin
            if (k < bits.size()) begin
               b_in.valid = 1'b1;
               b_in.data  = bits[k];
               if (b_in.ready === 1'b1) k++;
            end else begin
               b_in.valid = 1'b0;
            end
            tick();
            cyc++;
         end
      end
      b_in.valid = 1'b0;
   endtask

   task automatic test_reset();
      int nout = 0;
      int sent = 0;
      tests_run++;
      if (a_out.valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_valid: got %b want 0", a_out.valid);
      end
      tests_run++;
      if (a_out.data !== 6'd0) begin
         tests_failed++; $display("FAIL reset_out1: got %0d want 0", a_out.data);
      end
      tests_run++;
      if (a_in.ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_in_ready: got %b want 1", a_in.ready);
      end
      rst = 1'b0;
      a_out.ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a_in.valid = 1'b1; a_in.data = 1'b1;
         tick();
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (a_out.valid !== 1'b0 || a_out.data !== 6'd0) begin
         tests_failed++;
         $display("FAIL reset_mid: got valid=%b out1=%0d want valid=0 out1=0",
                  a_out.valid, a_out.data);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 90; c++) begin
         if (a_out.valid === 1'b1) begin
            nout++;
            tests_run++;
            if (a_out.data !== 6'd63) begin
               tests_failed++; $display("FAIL reset_fresh_window: got %0d want 63", a_out.data);
            end
         end
         if (sent < 63) begin
            a_in.valid = 1'b1; a_in.data = 1'b1;
            if (a_in.ready === 1'b1) sent++;
         end else begin
            a_in.valid = 1'b0;
         end
         tick();
      end
      tests_run++;
      if (nout != 1) begin
         tests_failed++; $display("FAIL reset_output_count: got %0d want 1", nout);
      end
   endtask

   task automatic test_alternating();
      int vals[$];
      int rises[$];
      int k = 0;
      int exp_v;
      clear_a = 1'b1; tick(); clear_a = 1'b0;
      a_out.ready = 1'b1;
      for (int c = 0; c < 400 && vals.size() < 4; c++) begin
         if (a_out.valid === 1'b1) begin
            vals.push_back(int'(a_out.data));
            rises.push_back(c);
            tests_run++;
            if (a_in.ready !== 1'b0) begin
               tests_failed++; $display("FAIL alt_in_ready_hold: got %b want 0", a_in.ready);
            end
         end
         a_in.valid = 1'b1;
         a_in.data  = (k % 2 == 0);
         if (a_in.ready === 1'b1) k++;
         tick();
      end
      a_in.valid = 1'b0;
      tests_run++;
      if (vals.size() != 4) begin
         tests_failed++; $display("FAIL alt_count: got %0d want 4", vals.size());
      end else begin
         for (int w = 0; w < 4; w++) begin
            exp_v = 0;
            for (int j = w * 63; j < w * 63 + 63; j++) exp_v += (j % 2 == 0) ? 1 : 0;
            tests_run++;
            if (vals[w] != exp_v) begin
               tests_failed++; $display("FAIL alt_value[%0d]: got %0d want %0d", w, vals[w], exp_v);
            end
            if (w > 0) begin
               tests_run++;
               if (rises[w] - rises[w-1] != 64) begin
                  tests_failed++;
                  $display("FAIL alt_period: got %0d want 64", rises[w] - rises[w-1]);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit bits[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      bit zeros[$];
      int exp_v = 0;
      int k = 0;
      int cyc = 0;
      logic [5:0] v;
      bit got;
      foreach (bits[i]) exp_v += bits[i];
      clear_b = 1'b1; tick(); clear_b = 1'b0;
      b_out.ready = 1'b0;
      while (cyc < 100 && b_out.valid !== 1'b1) begin
         if (k < 8 && cyc % 2 == 0) begin
            b_in.valid = 1'b1; b_in.data = bits[k];
            if (b_in.ready === 1'b1) k++;
         end else begin
            b_in.valid = 1'b0;
         end
         tick();
         cyc++;
      end
      tests_run++;
      if (b_out.valid !== 1'b1) begin
         tests_failed++; $display("FAIL bp_wait_valid: got %b want 1", b_out.valid);
      end
      b_in.valid = 1'b1; b_in.data = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (b_out.valid !== 1'b1 || b_out.data !== 6'(exp_v) || b_in.ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: got valid=%b out1=%0d in_ready=%b want 1/%0d/0",
                     i, b_out.valid, b_out.data, b_in.ready, exp_v);
         end
         tick();
      end
      b_in.valid = 1'b0;
      b_out.ready = 1'b1;
      tick();
      tests_run++;
      if (b_out.valid !== 1'b0 || b_in.ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_release: got valid=%b in_ready=%b want 0/1", b_out.valid, b_in.ready);
      end
      for (int i = 0; i < 8; i++) zeros.push_back(1'b0);
      stream_b(zeros, v, got);
      tests_run++;
      if (!got || v !== 6'd0) begin
         tests_failed++; $display("FAIL bp_no_hold_count: got %0d (seen %0d) want 0", v, got);
      end
   endtask

   task automatic test_clear_mid();
      bit zeros[$];
      logic [5:0] v;
      bit got;
      clear_b = 1'b1; tick(); clear_b = 1'b0;
      b_out.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_in.valid = 1'b1; b_in.data = 1'b1;
         tick();
      end
      clear_b = 1'b1; b_in.valid = 1'b1; b_in.data = 1'b1;
      tick();
      clear_b = 1'b0; b_in.valid = 1'b0;
      for (int i = 0; i < 8; i++) zeros.push_back(1'b0);
      stream_b(zeros, v, got);
      tests_run++;
      if (!got || v !== 6'd0) begin
         tests_failed++; $display("FAIL clear_mid: got %0d (seen %0d) want 0", v, got);
      end
   endtask

   task automatic test_clear_hold();
      bit ones8[$];
      logic [5:0] v;
      bit got;
      int cyc = 0;
      clear_b = 1'b1; tick(); clear_b = 1'b0;
      b_out.ready = 1'b0;
      while (cyc < 50 && b_out.valid !== 1'b1) begin
         b_in.valid = 1'b1; b_in.data = 1'b1;
         tick();
         cyc++;
      end
      b_in.valid = 1'b0;
      tests_run++;
      if (b_out.valid !== 1'b1) begin
         tests_failed++; $display("FAIL clear_hold_wait: got %b want 1", b_out.valid);
      end
      clear_b = 1'b1; b_out.ready = 1'b1;
      tick();
      clear_b = 1'b0;
      tests_run++;
      if (b_out.valid !== 1'b0 || b_in.ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL clear_hold: got valid=%b in_ready=%b want 0/1", b_out.valid, b_in.ready);
      end
      for (int i = 0; i < 8; i++) ones8.push_back(1'b1);
      stream_b(ones8, v, got);
      tests_run++;
      if (!got || v !== 6'd8) begin
         tests_failed++; $display("FAIL clear_hold_next: got %0d (seen %0d) want 8", v, got);
      end
   endtask

   task automatic test_window1();
      bit bits[3] = '{1'b1, 1'b0, 1'b1};
      int vals[$];
      int rises[$];
      int k = 0;
      clear_c = 1'b1; tick(); clear_c = 1'b0;
      c_out.ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c_out.valid === 1'b1) begin
            vals.push_back(int'(c_out.data));
            rises.push_back(c);
         end
         if (k < 3) begin
            c_in.valid = 1'b1; c_in.data = bits[k];
            if (c_in.ready === 1'b1) k++;
         end else begin
            c_in.valid = 1'b0;
         end
         tick();
      end
      tests_run++;
      if (vals.size() != 3) begin
         tests_failed++; $display("FAIL w1_count: got %0d want 3", vals.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (vals[i] != int'(bits[i])) begin
               tests_failed++; $display("FAIL w1_value[%0d]: got %0d want %0d", i, vals[i], bits[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            tests_run++;
            if (rises[i] - rises[i-1] != 2) begin
               tests_failed++;
               $display("FAIL w1_period: got %0d want 2", rises[i] - rises[i-1]);
            end
         end
      end
   endtask

   task automatic test_random();
      bit acc[$];
      bit m_hold = 1'b0;
      int m_val = 0;
      int s;
      bit clr, v, d, r;
      clear_b = 1'b1; tick(); clear_b = 1'b0;
      for (int c = 0; c < 600; c++) begin
         tests_run++;
         if (b_out.valid !== m_hold || b_in.ready !== !m_hold ||
             (m_hold && b_out.data !== 6'(m_val))) begin
            tests_failed++;
            $display("FAIL rand[%0d]: got valid=%b in_ready=%b out1=%0d want %b/%b/%0d",
                     c, b_out.valid, b_in.ready, b_out.data, m_hold, !m_hold, m_val);
         end
         clr = ($urandom_range(0, 31) == 0);
         v   = 1'($urandom_range(0, 1));
         d   = 1'($urandom_range(0, 1));
         r   = ($urandom_range(0, 3) != 0);
         clear_b = clr; b_in.valid = v; b_in.data = d; b_out.ready = r;
         if (clr) begin
            acc.delete();
            m_hold = 1'b0;
         end else if (!m_hold && v) begin
            acc.push_back(d);
            if (acc.size() == 8) begin
               s = 0;
               foreach (acc[i]) s += acc[i];
               m_val = s;
               acc.delete();
               m_hold = 1'b1;
            end
         end else if (m_hold && r) begin
            m_hold = 1'b0;
         end
         tick();
      end
      clear_b = 1'b0; b_in.valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
      a_in.valid = 1'b0; a_in.data = 1'b0; a_out.ready = 1'b0;
      b_in.valid = 1'b0; b_in.data = 1'b0; b_out.ready = 1'b0;
      c_in.valid = 1'b0; c_in.data = 1'b0; c_out.ready = 1'b0;
      tick();
      tick();
      test_reset();
      test_alternating();
      test_backpressure();
      test_clear_mid();
      test_clear_hold();
      test_window1();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
